// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and receiver state encoding
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - generic 2-flop synchronizer, both flops reset to RESET_VAL
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with valid/read holding register
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int MID        = OVERSAMPLE / 2 - 1
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] TC_MID  = TCW'(MID);
  localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_rx_state_e       r_state;
  logic [TCW-1:0]       r_tick_cnt;
  logic [BCW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun_err;
  logic                 r_wait_high;

`ifdef UART_RX_PARITY_EN
  logic r_parity_bit;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (sys_clk),
    .i_reset (reset),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_wait_high   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_bit  <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      if (rd_en) r_rx_valid <= 1'b0;
      if (baud_tick) begin
        case (r_state)
          ST_IDLE: begin
            r_tick_cnt <= '0;
            // After a low stop bit the line must go high before a new start is armed
            if (r_wait_high) begin
              if (w_rx_s) r_wait_high <= 1'b0;
            end else if (!w_rx_s) begin
              r_state <= ST_START;
            end
          end
          ST_START: begin
            if (r_tick_cnt == TC_MID) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rx_s ? ST_IDLE : ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TCW'(1);
            end
          end
          ST_DATA: begin
            r_tick_cnt <= (r_tick_cnt == TC_LAST) ? '0 : r_tick_cnt + TCW'(1);
            if (r_tick_cnt == TC_LAST) begin
              r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              if (r_bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            r_tick_cnt <= (r_tick_cnt == TC_LAST) ? '0 : r_tick_cnt + TCW'(1);
            if (r_tick_cnt == TC_LAST) begin
              r_parity_bit <= w_rx_s;
              r_state      <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            r_tick_cnt <= (r_tick_cnt == TC_LAST) ? '0 : r_tick_cnt + TCW'(1);
            if (r_tick_cnt == TC_LAST) begin
              r_rx_data     <= r_shift;
              r_frame_err   <= ~w_rx_s;
              r_overrun_err <= r_rx_valid & ~rd_en;
              r_rx_valid    <= 1'b1;
              r_wait_high   <= ~w_rx_s;
              r_tick_cnt    <= '0;
              r_state       <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              r_parity_err  <= ^{r_shift, r_parity_bit};
`endif
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule
